// File: rtl/axis_fifo_pkg.sv
// Shared defaults and sizing helpers for the AXI-Stream packet FIFO.
// Imported by the FIFO top and its storage sub-module.
package axis_fifo_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_PACKET_MODE = 1;

    // Occupancy counters need one extra bit to represent a completely full FIFO.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Each word holds {tlast, tdata}.
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with optional store-and-forward packet gating.
// A full FIFO holding no complete packet is released in cut-through fashion.
module axis_packet_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int PACKET_MODE = DEF_PACKET_MODE,
    localparam int CW         = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] input_tdata,
    input  logic                  input_tvalid,
    output logic                  input_tready,
    input  logic                  input_tlast,
    output logic [DATA_WIDTH-1:0] output_tdata,
    output logic                  output_tvalid,
    input  logic                  output_tready,
    output logic                  output_tlast,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         pkt_count,
    output logic                  oversize
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [DATA_WIDTH:0] rd_word;
    logic                full;
    logic                empty;
    logic                forced;
    logic                oversize_q;
    logic                wr_en;
    logic                rd_en;
    logic                wr_last;
    logic                rd_last;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Forced release: nothing will ever complete a packet once full.
    assign forced = (PACKET_MODE != 0) && full && (pkt_count == '0);

    always_comb begin
        output_tvalid = !empty;
        if (PACKET_MODE != 0) begin
            output_tvalid = !empty && ((pkt_count != '0) || full);
        end
    end

    assign input_tready = !full;
    assign wr_en        = input_tvalid && input_tready;
    assign rd_en        = output_tvalid && output_tready;
    assign wr_last      = wr_en && input_tlast;
    assign rd_last      = rd_en && output_tlast;

    assign {output_tlast, output_tdata} = rd_word;
    assign oversize = oversize_q || forced;

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en && !reset),
        .wr_addr (wr_ptr),
        .wr_data ({input_tlast, input_tdata}),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_count  <= '0;
            oversize_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({wr_last, rd_last})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
            if (forced) begin
                oversize_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: three configurations against a queue model,
// plus directed scenarios with literal expectations.
module tb_axis_packet_fifo;

    localparam int N = 3;
    // u0: cut-through D16, u1: store-and-forward D16, u2: cut-through D4
    localparam int PM [N] = '{0, 1, 0};
    localparam int DP [N] = '{16, 16, 4};

    logic       clk;
    logic       rst;
    logic [7:0] itd [N];
    logic       itv [N];
    logic       itl [N];
    logic       otr [N];

    wire        itr [N];
    wire  [7:0] otd [N];
    wire        otv [N];
    wire        otl [N];
    wire  [4:0] cnt [N];
    wire  [4:0] pkt [N];
    wire        ovs [N];
    wire  [2:0] cnt2;
    wire  [2:0] pkt2;

    assign cnt[2] = {2'b00, cnt2};
    assign pkt[2] = {2'b00, pkt2};

    axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(0)) u0 (
        .clk(clk), .reset(rst),
        .input_tdata(itd[0]), .input_tvalid(itv[0]), .input_tready(itr[0]),
        .input_tlast(itl[0]), .output_tdata(otd[0]), .output_tvalid(otv[0]),
        .output_tready(otr[0]), .output_tlast(otl[0]),
        .count(cnt[0]), .pkt_count(pkt[0]), .oversize(ovs[0])
    );

    axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(1)) u1 (
        .clk(clk), .reset(rst),
        .input_tdata(itd[1]), .input_tvalid(itv[1]), .input_tready(itr[1]),
        .input_tlast(itl[1]), .output_tdata(otd[1]), .output_tvalid(otv[1]),
        .output_tready(otr[1]), .output_tlast(otl[1]),
        .count(cnt[1]), .pkt_count(pkt[1]), .oversize(ovs[1])
    );

    axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(4), .PACKET_MODE(0)) u2 (
        .clk(clk), .reset(rst),
        .input_tdata(itd[2]), .input_tvalid(itv[2]), .input_tready(itr[2]),
        .input_tlast(itl[2]), .output_tdata(otd[2]), .output_tvalid(otv[2]),
        .output_tready(otr[2]), .output_tlast(otl[2]),
        .count(cnt2), .pkt_count(pkt2), .oversize(ovs[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit armed = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each FIFO is a queue of {tlast, tdata} words.
    logic [8:0] q [N][$];
    bit         m_sticky [N];

    function automatic int m_cnt(input int i);
        return q[i].size();
    endfunction

    function automatic int m_pkt(input int i);
        int n = 0;
        for (int k = 0; k < q[i].size(); k++) begin
            if (q[i][k][8]) n++;
        end
        return n;
    endfunction

    function automatic bit m_ready(input int i);
        return m_cnt(i) != DP[i];
    endfunction

    function automatic bit m_valid(input int i);
        if (m_cnt(i) == 0) return 1'b0;
        if (PM[i] == 0) return 1'b1;
        return (m_pkt(i) != 0) || (m_cnt(i) == DP[i]);
    endfunction

    function automatic bit m_ovs(input int i);
        return m_sticky[i] ||
               (PM[i] != 0 && m_cnt(i) == DP[i] && m_pkt(i) == 0);
    endfunction

    always @(posedge clk) begin
        bit wr, rd;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                q[i].delete();
                m_sticky[i] = 1'b0;
            end else begin
                wr = itv[i] && m_ready(i);
                rd = m_valid(i) && otr[i];
                if (m_ovs(i)) m_sticky[i] = 1'b1;
                if (rd) void'(q[i].pop_front());
                if (wr) q[i].push_back({itl[i], itd[i]});
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("u%0d_ready", i), itr[i], m_ready(i));
                chk($sformatf("u%0d_valid", i), otv[i], m_valid(i));
                chk($sformatf("u%0d_count", i), cnt[i], m_cnt(i));
                chk($sformatf("u%0d_pkt", i), pkt[i], m_pkt(i));
                chk($sformatf("u%0d_ovs", i), ovs[i], m_ovs(i));
                if (m_valid(i)) begin
                    chk($sformatf("u%0d_data", i), otd[i], q[i][0][7:0]);
                    chk($sformatf("u%0d_last", i), otl[i], q[i][0][8]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int i, input int budget);
        int n = 0;
        itv[i] = 1'b0;
        otr[i] = 1'b1;
        while (cnt[i] != 0 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("u%0d_drain", i), cnt[i], 0);
    endtask

    initial begin
        int b, recv, n;
        bit seen, acc;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            itd[i] = 8'h00; itv[i] = 1'b0; itl[i] = 1'b0; otr[i] = 1'b0;
        end
        tick();
        armed = 1;
        tick();
        for (int i = 0; i < N; i++) begin
            chk("rst_ready", itr[i], 1);
            chk("rst_valid", otv[i], 0);
            chk("rst_count", cnt[i], 0);
            chk("rst_pkt", pkt[i], 0);
            chk("rst_ovs", ovs[i], 0);
        end
        rst = 1'b0;
        tick();

        // Cut-through: each byte visible one cycle after its write
        otr[0] = 1'b1;
        itv[0] = 1'b1; itd[0] = 8'h11; itl[0] = 1'b0;
        tick();
        chk("ct_v1", otv[0], 1); chk("ct_d1", otd[0], 8'h11);
        itd[0] = 8'h22;
        tick();
        chk("ct_d2", otd[0], 8'h22);
        itd[0] = 8'h33; itl[0] = 1'b1;
        tick();
        chk("ct_d3", otd[0], 8'h33); chk("ct_l3", otl[0], 1);
        itv[0] = 1'b0; itl[0] = 1'b0;
        tick();
        chk("ct_cnt0", cnt[0], 0);

        // Store-and-forward: held until tlast is written
        otr[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            itv[1] = 1'b1; itd[1] = 8'(8'hA0 + k); itl[1] = (k == 4);
            tick();
            if (k < 4) chk("sf_hold", otv[1], 0);
        end
        itv[1] = 1'b0; itl[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("sf_valid", otv[1], 1);
            chk("sf_data", otd[1], 8'(8'hA0 + k));
            chk("sf_last", otl[1], (k == 4));
            chk("sf_pkt1", pkt[1], 1);
            tick();
        end
        chk("sf_pkt0", pkt[1], 0);
        chk("sf_empty", otv[1], 0);

        // Full boundary with single-beat packets
        otr[1] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            itv[1] = 1'b1; itd[1] = 8'(8'h40 + k); itl[1] = 1'b1;
            tick();
        end
        chk("full_ready", itr[1], 0);
        chk("full_cnt", cnt[1], 16);
        chk("full_pkt", pkt[1], 16);
        itd[1] = 8'hFF;
        tick();
        chk("full_ignored", cnt[1], 16);
        otr[1] = 1'b1;
        tick();
        chk("full_rdy_back", itr[1], 1);
        chk("full_cnt15", cnt[1], 15);
        tick();
        chk("full_rw_cnt", cnt[1], 15);
        drain(1, 40);

        // Oversize packet forced out of the store-and-forward FIFO
        b = 0; recv = 0; n = 0; seen = 0;
        otr[1] = 1'b1;
        while ((b < 20 || cnt[1] != 0) && n < 200) begin
            itv[1] = (b < 20); itd[1] = 8'(8'h80 + b); itl[1] = (b == 19);
            if (cnt[1] == 16 && !seen) begin
                seen = 1;
                chk("ovs_flag", ovs[1], 1);
                chk("ovs_valid", otv[1], 1);
                chk("ovs_pkt", pkt[1], 0);
            end
            acc = itv[1] && itr[1];
            if (otv[1]) begin
                chk("ovs_order", otd[1], 8'(8'h80 + recv));
                recv++;
            end
            tick();
            n++;
            if (acc) b++;
        end
        itv[1] = 1'b0; itl[1] = 1'b0;
        chk("ovs_seen_full", seen, 1);
        chk("ovs_beats", recv, 20);
        chk("ovs_sticky", ovs[1], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovs_cleared", ovs[1], 0);

        // Depth-4 continuous stream wraps the pointers
        otr[2] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            itv[2] = 1'b1; itd[2] = 8'(k);
            chk("wrap_rdy", itr[2], 1);
            if (k > 0) begin
                chk("wrap_vld", otv[2], 1);
                chk("wrap_data", otd[2], 8'(k - 1));
                chk("wrap_cnt", cnt[2], 1);
            end
            tick();
        end
        itv[2] = 1'b0;
        chk("wrap_d15", otd[2], 8'h0F);
        tick();
        chk("wrap_cnt0", cnt[2], 0);

        // Reset mid-packet discards the partial packet
        otr[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            itv[1] = 1'b1; itd[1] = 8'(8'h31 + k); itl[1] = 1'b0;
            tick();
        end
        chk("mid_cnt3", cnt[1], 3);
        itv[1] = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_cnt", cnt[1], 0);
        chk("mid_rst_pkt", pkt[1], 0);
        chk("mid_rst_vld", otv[1], 0);
        chk("mid_rst_rdy", itr[1], 1);
        rst = 1'b0;
        itv[1] = 1'b1; itd[1] = 8'h5A; itl[1] = 1'b0;
        tick();
        chk("mid_hold", otv[1], 0);
        itd[1] = 8'h5B; itl[1] = 1'b1;
        tick();
        itv[1] = 1'b0; itl[1] = 1'b0;
        chk("mid_d0", otd[1], 8'h5A);
        chk("mid_v0", otv[1], 1);
        tick();
        chk("mid_d1", otd[1], 8'h5B);
        chk("mid_l1", otl[1], 1);
        tick();
        chk("mid_cnt0", cnt[1], 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
